decimal_to_binary: RTL and testbench

- Sequential BCD-to-binary converter. It is the inverse of the display path's binary-to-decimal conversion.
- Takes a packed multi-digit BCD value, such as a time typed on the egg-timer keypad, and produces the binary count used by the countdown logic.
- Processes one digit per clock, most-significant first, using a start/valid handshake.
- Sits between the digit-entry logic and the timer counter load port.

---
 rtl/bcd_defs.sv | 24 ++
 rtl/bcd_digit_mac.sv | 39 +++
 rtl/decimal_to_binary.sv | 168 ++++++++++++++++
 tb/tb_decimal_to_binary.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_defs.sv
// ============================================================================
//  Module      : bcd_defs (package)
//  Description : Shared constants for the BCD-to-binary conversion path:
//                digit width, largest legal digit and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_defs;

  // Width of one packed BCD digit
  localparam int BCD_DIGIT_W = 4;

  // Largest legal value of a BCD digit
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Converter FSM state encodings
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

endpackage : bcd_defs

`default_nettype wire

// File: rtl/bcd_digit_mac.sv
// ============================================================================
//  Module      : bcd_digit_mac
//  Description : Combinational multiply-accumulate step for BCD conversion:
//                result = acc*10 + digit, modulo 2^BIN_W.
//                The digit range comparator (digit_invalid) only exists when
//                DECIMAL_TO_BINARY_DIGIT_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_mac
  import bcd_defs::*;
#(
  parameter int BIN_W = 16
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       result
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
  ,
  output logic                   digit_invalid
`endif
);

  // acc*10 built from two shifts so no multiplier is inferred
  always_comb begin
    result = (acc << 3) + (acc << 1) + BIN_W'(digit);
  end

`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
  // Flag nibbles 10..15, which are not legal BCD digits
  always_comb begin
    digit_invalid = (digit > BCD_MAX_DIGIT);
  end
`endif

endmodule : bcd_digit_mac

`default_nettype wire

// File: rtl/decimal_to_binary.sv
// ============================================================================
//  Module      : decimal_to_binary
//  Description : Sequential packed-BCD to binary converter. One digit is
//                folded into the accumulator per clock, most-significant
//                digit first, with a start / valid handshake.
//                Optional build macro: DECIMAL_TO_BINARY_DIGIT_CHECK_EN
//                (enables digit range checking and out_error).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decimal_to_binary
  import bcd_defs::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_decimal,
  output logic [BIN_W-1:0]              out_binary,
  output logic                          out_valid,
  output logic                          out_busy,
  output logic                          out_error
);

  localparam int               DEC_W    = BCD_DIGIT_W * DIGITS;
  localparam int               CNT_W    = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [DEC_W-1:0] shift_q, shift_d;
  logic [BIN_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic             valid_q, valid_d;

  logic [BIN_W-1:0]       mac_result;
  logic [BCD_DIGIT_W-1:0] top_digit;
  logic                   last_digit;

  assign top_digit  = shift_q[DEC_W-1 -: BCD_DIGIT_W];
  assign last_digit = (cnt_q == LAST_CNT);

`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
  logic err_q,   err_d;
  logic error_q, error_d;
  logic digit_invalid;

  bcd_digit_mac #(
    .BIN_W         (BIN_W)
  ) u_mac (
    .acc           (acc_q),
    .digit         (top_digit),
    .result        (mac_result),
    .digit_invalid (digit_invalid)
  );

  assign out_error = error_q;
`else
  bcd_digit_mac #(
    .BIN_W  (BIN_W)
  ) u_mac (
    .acc    (acc_q),
    .digit  (top_digit),
    .result (mac_result)
  );

  assign out_error = 1'b0;
`endif

  assign out_binary = bin_q;
  assign out_valid  = valid_q;
  assign out_busy   = (state_q != S_IDLE);

  // FSM state register; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start only accepted in IDLE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_start)   state_d = S_CONVERT;
      S_CONVERT: if (last_digit) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values driven by the current state
  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
    err_d   = err_q;
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_start) begin
          shift_d = in_decimal;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_CONVERT: begin
        acc_d   = mac_result;
        shift_d = shift_q << BCD_DIGIT_W;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
        err_d   = err_q | digit_invalid;
`endif
        if (last_digit) begin
          valid_d = 1'b1;
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
          // Include the final digit's check in the reported flag
          error_d = err_d;
          bin_d   = err_d ? '0 : mac_result;
`else
          bin_d   = mac_result;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
      err_q   <= 1'b0;
      error_q <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
      err_q   <= err_d;
      error_q <= error_d;
`endif
    end
  end

endmodule : decimal_to_binary

`default_nettype wire

// File: tb/tb_decimal_to_binary.sv
// ============================================================================
//  Module      : tb_decimal_to_binary
//  Description : Self-checking bench for decimal_to_binary with a queue of
//                expected results consumed on every out_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decimal_to_binary;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_start = 1'b0;
  logic [15:0] in_decimal = 16'h0000;
  logic [15:0] out_binary;
  logic        out_valid;
  logic        out_busy;
  logic        out_error;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  logic [15:0] exp_bin_q[$];
  logic        exp_err_q[$];

  decimal_to_binary #(
    .DIGITS     (4),
    .BIN_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_start   (in_start),
    .in_decimal (in_decimal),
    .out_binary (out_binary),
    .out_valid  (out_valid),
    .out_busy   (out_busy),
    .out_error  (out_error)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid pulse pops one expected result
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      logic [15:0] eb;
      logic        ee;
      vcount++;
      checks++;
      if (exp_bin_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: out_binary=%0d with nothing expected", out_binary);
      end else begin
        eb = exp_bin_q.pop_front();
        ee = exp_err_q.pop_front();
        if (out_binary !== eb) begin
          errors++;
          $display("FAIL result: out_binary=%0d expected %0d", out_binary, eb);
        end
        checks++;
        if (out_error !== ee) begin
          errors++;
          $display("FAIL error_flag: out_error=%b expected %b", out_error, ee);
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_conv(input logic [15:0] d, input logic [15:0] eb, input logic ee);
    int v0;
    int n;
    @(negedge clk);
    in_decimal = d;
    in_start   = 1'b1;
    exp_bin_q.push_back(eb);
    exp_err_q.push_back(ee);
    v0 = vcount;
    @(negedge clk);
    in_start = 1'b0;
    n = 0;
    while (vcount == v0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (vcount == v0) begin
      errors++;
      $display("FAIL conv_timeout: in=%h got no valid, expected one", d);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_binary, out_valid, out_busy, out_error} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: bin=%0d v=%b b=%b e=%b expected all 0",
               out_binary, out_valid, out_busy, out_error);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_decimal = 16'h1234;
    in_start   = 1'b1;
    exp_bin_q.push_back(16'd1234);
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    in_start = 1'b0;
    checks++;
    if (out_busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_start: busy=%b valid=%b expected 1 0", out_busy, out_valid);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid: valid=%b expected 0", out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_busy !== 1'b1) begin
      errors++;
      $display("FAIL latency: valid=%b busy=%b expected 1 1", out_valid, out_busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_binary !== 16'd1234) begin
      errors++;
      $display("FAIL pulse_end: valid=%b busy=%b bin=%0d expected 0 0 1234",
               out_valid, out_busy, out_binary);
    end
    run_conv(16'h9999, 16'd9999, 1'b0);
    run_conv(16'h0000, 16'd0, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int v0;
    @(negedge clk);
    in_decimal = 16'h0042;
    in_start   = 1'b1;
    exp_bin_q.push_back(16'd42);
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    in_start = 1'b0;
    @(negedge clk);
    in_decimal = 16'h0777;
    in_start   = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    v0 = vcount;
    repeat (12) @(posedge clk);
    checks++;
    if (vcount != v0 + 1) begin
      errors++;
      $display("FAIL ignore_busy: valid pulses=%0d expected 1", vcount - v0);
    end
    checks++;
    if (out_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_idle: busy=%b expected 0", out_busy);
    end
    run_conv(16'h0777, 16'd777, 1'b0);
  endtask

  task automatic test_reset_mid();
    int v0;
    @(negedge clk);
    in_decimal = 16'h5678;
    in_start   = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    @(negedge clk);
    v0  = vcount;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_binary, out_valid, out_busy, out_error} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid: bin=%0d v=%b b=%b e=%b expected all 0",
               out_binary, out_valid, out_busy, out_error);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    checks++;
    if (vcount != v0) begin
      errors++;
      $display("FAIL reset_no_valid: valid pulses=%0d expected 0", vcount - v0);
    end
    run_conv(16'h0100, 16'd100, 1'b0);
  endtask

  task automatic test_invalid_digit();
`ifdef DECIMAL_TO_BINARY_DIGIT_CHECK_EN
    run_conv(16'h12A4, 16'd0, 1'b1);
    checks++;
    if (out_error !== 1'b1) begin
      errors++;
      $display("FAIL error_hold: out_error=%b expected 1", out_error);
    end
    run_conv(16'h0001, 16'd1, 1'b0);
`else
    run_conv(16'h12A4, 16'd1304, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    int times[$];
    int n;
    @(negedge clk);
    in_decimal = 16'h0010;
    in_start   = 1'b1;
    repeat (3) begin
      exp_bin_q.push_back(16'd10);
      exp_err_q.push_back(1'b0);
    end
    n = 0;
    while (n < 24) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) times.push_back(n);
      if (n == 18) in_start = 1'b0;
    end
    checks++;
    if (times.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d expected 3", times.size());
    end else begin
      checks++;
      if (times[1] - times[0] != 6 || times[2] - times[1] != 6) begin
        errors++;
        $display("FAIL b2b_period: gaps=%0d,%0d expected 6,6",
                 times[1] - times[0], times[2] - times[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_reset_mid();
    test_invalid_digit();
    test_back_to_back();
    repeat (4) @(posedge clk);
    checks++;
    if (exp_bin_q.size() != 0) begin
      errors++;
      $display("FAIL missing_valid: %0d results outstanding, expected 0", exp_bin_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decimal_to_binary

`default_nettype wire
